// File: rtl/alu_chk_pkg.sv
// Shared definitions for the ALU stimulus/checker: opcodes, FSM states,
// command record layout and a sizing helper.
package alu_chk_pkg;

  // ALU opcode encodings (ALU_Sel)
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_NOT = 3'b101;
  localparam logic [2:0] OP_SHL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  // Default interface widths
  localparam int CHK_DATA_W = 4;
  localparam int CHK_SEL_W  = 3;

  // Checker sequencing states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    REPORT = 2'd2
  } chk_state_e;

  // Queued check command; the FIFO stores the same field order flattened
  // (a in the MSBs down to exp_carry in bit 0).
  typedef struct packed {
    logic [CHK_DATA_W-1:0] a;
    logic [CHK_DATA_W-1:0] b;
    logic [CHK_SEL_W-1:0]  sel;
    logic [CHK_DATA_W-1:0] exp_out;
    logic                  exp_carry;
  } alu_cmd_t;

  // Bits needed to store one command for the given interface widths.
  function automatic int cmd_entry_w(input int data_w, input int sel_w);
    return (3 * data_w) + sel_w + 1;
  endfunction

endpackage

// File: rtl/alu_chk_fifo.sv
// Synchronous show-ahead FIFO holding flattened check commands.
// Push is ignored when full, pop is ignored when empty.
module alu_chk_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [AW:0]      count_r;
  logic             do_push_s;
  logic             do_pop_s;

  // Qualify requests against the current occupancy flags.
  always_comb begin
    full      = (count_r == (AW + 1)'(DEPTH));
    empty     = (count_r == '0);
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    rdata     = mem_r[rd_ptr_r];
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW + 1)'(1);
        2'b01:   count_r <= count_r - (AW + 1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/alu_stim_checker.sv
// Self-checking driver for a combinational ALU: queues check commands,
// drives them one at a time, samples the result after a settle delay,
// reports pass/fail per transaction and keeps saturating statistics.
module alu_stim_checker
  import alu_chk_pkg::*;
#(
  parameter int DATA_W        = 4,
  parameter int SEL_W         = 3,
  parameter int FIFO_DEPTH    = 4,
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [SEL_W-1:0]  cmd_sel,
  input  logic [DATA_W-1:0] cmd_exp_out,
  input  logic              cmd_exp_carry,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              alu_carry,
  output logic              rpt_valid,
  input  logic              rpt_ready,
  output logic              rpt_pass,
  output logic [SEL_W-1:0]  rpt_sel,
  output logic [DATA_W-1:0] rpt_got_out,
  output logic              rpt_got_carry,
  output logic [CNT_W-1:0]  pass_cnt,
  output logic [CNT_W-1:0]  fail_cnt,
  output logic              err_sticky,
  input  logic              clr_stats,
  output logic              busy
);

  localparam int ENTRY_W = cmd_entry_w(DATA_W, SEL_W);
  localparam int SCW     = $clog2(SETTLE_CYCLES + 1);

  chk_state_e        state_r;
  chk_state_e        state_nxt_s;

  logic [ENTRY_W-1:0] push_data_s;
  logic [ENTRY_W-1:0] head_s;
  logic               fifo_full_s;
  logic               fifo_empty_s;
  logic               push_s;
  logic               pop_s;

  logic [DATA_W-1:0]  head_a_s;
  logic [DATA_W-1:0]  head_b_s;
  logic [SEL_W-1:0]   head_sel_s;
  logic [DATA_W-1:0]  head_exp_out_s;
  logic               head_exp_carry_s;

  logic [DATA_W-1:0]  exp_out_r;
  logic               exp_carry_r;
  logic [SCW-1:0]     settle_cnt_r;

  logic               load_s;
  logic               sample_s;
  logic               rpt_clr_s;
  logic               match_s;

  assign push_data_s = {cmd_a, cmd_b, cmd_sel, cmd_exp_out, cmd_exp_carry};
  assign {head_a_s, head_b_s, head_sel_s, head_exp_out_s, head_exp_carry_s} = head_s;

  // Accept side and status: ready follows FIFO space and is held low in reset.
  always_comb begin
    cmd_ready = rst_n && !fifo_full_s;
    push_s    = cmd_valid && cmd_ready;
    busy      = !fifo_empty_s || (state_r != IDLE);
    match_s   = ({alu_out, alu_carry} == {exp_out_r, exp_carry_r});
  end

  alu_chk_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_s),
    .wdata (push_data_s),
    .pop   (pop_s),
    .rdata (head_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic and per-edge control strobes.
  always_comb begin
    state_nxt_s = state_r;
    pop_s       = 1'b0;
    load_s      = 1'b0;
    sample_s    = 1'b0;
    rpt_clr_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (!fifo_empty_s) begin
          pop_s       = 1'b1;
          load_s      = 1'b1;
          state_nxt_s = SETTLE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      SETTLE: begin
        if (settle_cnt_r == SCW'(1)) begin
          sample_s    = 1'b1;
          state_nxt_s = REPORT;
        end else begin
          state_nxt_s = SETTLE;
        end
      end
      REPORT: begin
        if (rpt_valid && rpt_ready) begin
          rpt_clr_s = 1'b1;
          if (!fifo_empty_s) begin
            pop_s       = 1'b1;
            load_s      = 1'b1;
            state_nxt_s = SETTLE;
          end else begin
            state_nxt_s = IDLE;
          end
        end else begin
          state_nxt_s = REPORT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Operand drive, expected-value latch and settle countdown.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a        <= '0;
      alu_b        <= '0;
      alu_sel      <= '0;
      exp_out_r    <= '0;
      exp_carry_r  <= 1'b0;
      settle_cnt_r <= '0;
    end else if (load_s) begin
      alu_a        <= head_a_s;
      alu_b        <= head_b_s;
      alu_sel      <= head_sel_s;
      exp_out_r    <= head_exp_out_s;
      exp_carry_r  <= head_exp_carry_s;
      settle_cnt_r <= SCW'(SETTLE_CYCLES);
    end else if (state_r == SETTLE) begin
      settle_cnt_r <= settle_cnt_r - SCW'(1);
    end else begin
      settle_cnt_r <= settle_cnt_r;
    end
  end

  // Per-transaction report, held until the consumer takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rpt_valid     <= 1'b0;
      rpt_pass      <= 1'b0;
      rpt_sel       <= '0;
      rpt_got_out   <= '0;
      rpt_got_carry <= 1'b0;
    end else if (sample_s) begin
      rpt_valid     <= 1'b1;
      rpt_pass      <= match_s;
      rpt_sel       <= alu_sel;
      rpt_got_out   <= alu_out;
      rpt_got_carry <= alu_carry;
    end else if (rpt_clr_s) begin
      rpt_valid     <= 1'b0;
    end else begin
      rpt_valid     <= rpt_valid;
    end
  end

  // Running statistics; a clear on the sampling edge discards that sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      err_sticky <= 1'b0;
    end else if (clr_stats) begin
      pass_cnt   <= '0;
      fail_cnt   <= '0;
      err_sticky <= 1'b0;
    end else if (sample_s) begin
      if (match_s) begin
        if (pass_cnt != {CNT_W{1'b1}}) begin
          pass_cnt <= pass_cnt + CNT_W'(1);
        end else begin
          pass_cnt <= pass_cnt;
        end
      end else begin
        err_sticky <= 1'b1;
        if (fail_cnt != {CNT_W{1'b1}}) begin
          fail_cnt <= fail_cnt + CNT_W'(1);
        end else begin
          fail_cnt <= fail_cnt;
        end
      end
    end else begin
      pass_cnt <= pass_cnt;
    end
  end

endmodule
